regfile_write_arbiter: RTL and testbench

Write-back arbiter sitting directly upstream of the register file's single write port (WE3/A3/WD3). It merges two result streams, the single-cycle ALU result (never stalls) and the variable-latency load result (valid/ready), into one registered write per cycle. Pending load results are buffered in a small FIFO. Writes targeting R15 are diverted to a PC-update output instead of the register file. A per-register busy vector is exported for decode hazard detection.

---
 rtl/regfile_write_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges ALU and load results into one registered register-file/PC write per cycle (optional load bypass: REGFILE_WB_BYPASS_EN)
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [3:0]    alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [3:0]    ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic          WE3,
    output logic [3:0]    A3,
    output logic [DW-1:0] WD3,
    output logic          pc_we,
    output logic [DW-1:0] pc_data,
    output logic [15:0]   busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    fifo_rd   [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          hs;
    logic          pop;
    logic          bypass;
    logic          do_push;
    logic          sel_valid;
    logic [3:0]    sel_rd;
    logic [DW-1:0] sel_data;
    logic [15:0]   busy_c;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Acceptance depends only on registered occupancy, never on this cycle's pop
    assign ld_ready = (count < CW'(DEPTH)) && !reset;

    // Source selection: ALU first, then FIFO head, then (optionally) a direct load
    always_comb begin
        hs        = ld_valid && ld_ready;
        pop       = !alu_valid && (count != '0);
`ifdef REGFILE_WB_BYPASS_EN
        bypass    = !alu_valid && (count == '0) && hs;
`else
        bypass    = 1'b0;
`endif
        do_push   = hs && !bypass;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[head];
            sel_data  = fifo_data[head];
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
        end
    end

    // Load FIFO storage and pointers; reset discards anything buffered
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                fifo_rd[tail]   <= ld_rd;
                fifo_data[tail] <= ld_data;
                tail            <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output registers: R15 goes to the PC port, everything else to the register file
    always_ff @(posedge clk) begin
        if (reset) begin
            WE3     <= 1'b0;
            A3      <= '0;
            WD3     <= '0;
            pc_we   <= 1'b0;
            pc_data <= '0;
        end else if (sel_valid) begin
            if (sel_rd == 4'd15) begin
                WE3     <= 1'b0;
                pc_we   <= 1'b1;
                pc_data <= sel_data;
            end else begin
                WE3     <= 1'b1;
                A3      <= sel_rd;
                WD3     <= sel_data;
                pc_we   <= 1'b0;
            end
        end else begin
            WE3   <= 1'b0;
            pc_we <= 1'b0;
        end
    end

    // Busy map: output registers plus every occupied FIFO slot, walked from head
    always_comb begin
        busy_c = '0;
        if (WE3) busy_c[A3] = 1'b1;
        if (pc_we) busy_c[15] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                busy_c[fifo_rd[PW'((int'(head) + i) % DEPTH)]] = 1'b1;
            end
        end
    end

    assign busy = reset ? '0 : busy_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        pc_we;
    logic [31:0] pc_data;
    logic [15:0] busy;

    int errors = 0;
    int checks = 0;

`ifdef REGFILE_WB_BYPASS_EN
    localparam int LD_LAT = 1;
`else
    localparam int LD_LAT = 2;
`endif

    regfile_write_arbiter #(.DEPTH(2), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .pc_we(pc_we), .pc_data(pc_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [31:0] adat;
        logic        we;
        logic [3:0]  a3;
        logic [31:0] wd3;
        logic        pcwe;
        logic [31:0] pcd;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  wr_rd   [$];
    logic [31:0] wr_data [$];
    logic [3:0]  exp_rd   [7];
    logic [31:0] exp_data [7];
    logic [15:0] exp_busy;
    int          ld_idx;
    logic        hs;

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;

        vecs[0] = '{1'b1, 4'd2,  32'd100,        1'b1, 4'd2,  32'd100,        1'b0, 32'h0};
        vecs[1] = '{1'b0, 4'd0,  32'd0,          1'b0, 4'd2,  32'd100,        1'b0, 32'h0};
        vecs[2] = '{1'b1, 4'd15, 32'h40,         1'b0, 4'd2,  32'd100,        1'b1, 32'h40};
        vecs[3] = '{1'b0, 4'd0,  32'd0,          1'b0, 4'd2,  32'd100,        1'b0, 32'h40};
        vecs[4] = '{1'b1, 4'd0,  32'd7,          1'b1, 4'd0,  32'd7,          1'b0, 32'h40};
        vecs[5] = '{1'b1, 4'd14, 32'hdead,       1'b1, 4'd14, 32'hdead,       1'b0, 32'h40};
        vecs[6] = '{1'b1, 4'd15, 32'h80,         1'b0, 4'd14, 32'hdead,       1'b1, 32'h80};
        vecs[7] = '{1'b1, 4'd1,  32'hffffffff,   1'b1, 4'd1,  32'hffffffff,   1'b0, 32'h80};
        vecs[8] = '{1'b0, 4'd0,  32'd0,          1'b0, 4'd1,  32'hffffffff,   1'b0, 32'h80};

        // reset state
        tick(); tick();
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_pc_data", pc_data, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);

        // ALU / PC diversion vectors
        for (int v = 0; v < 9; v++) begin
            alu_valid = vecs[v].av; alu_rd = vecs[v].ard; alu_data = vecs[v].adat;
            tick();
            exp_busy = '0;
            if (vecs[v].we) exp_busy[vecs[v].a3] = 1'b1;
            if (vecs[v].pcwe) exp_busy[15] = 1'b1;
            chk($sformatf("v%0d_we3", v), 32'(WE3), 32'(vecs[v].we));
            chk($sformatf("v%0d_a3", v), 32'(A3), 32'(vecs[v].a3));
            chk($sformatf("v%0d_wd3", v), WD3, vecs[v].wd3);
            chk($sformatf("v%0d_pc_we", v), 32'(pc_we), 32'(vecs[v].pcwe));
            chk($sformatf("v%0d_pc_data", v), pc_data, vecs[v].pcd);
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(exp_busy));
        end
        alu_valid = 1'b0;

        // single load latency
        ld_valid = 1'b1; ld_rd = 4'd0; ld_data = 32'd256;
        chk("ld_ready_idle", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        chk("ld_busy0_n1", 32'(busy[0]), 32'd1);
        if (LD_LAT == 1) begin
            chk("ld_we3_n1", 32'(WE3), 32'd1);
            chk("ld_a3_n1", 32'(A3), 32'd0);
            chk("ld_wd3_n1", WD3, 32'd256);
        end else begin
            chk("ld_we3_n1", 32'(WE3), 32'd0);
            tick();
            chk("ld_we3_n2", 32'(WE3), 32'd1);
            chk("ld_a3_n2", 32'(A3), 32'd0);
            chk("ld_wd3_n2", WD3, 32'd256);
            chk("ld_busy0_n2", 32'(busy[0]), 32'd1);
        end
        tick();
        chk("ld_we3_after", 32'(WE3), 32'd0);
        chk("ld_busy_after", 32'(busy), 32'd0);

        // contention and back-pressure
        exp_rd   = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd3, 4'd4, 4'd5};
        exp_data = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd1, 32'd2, 32'd3};
        wr_rd.delete(); wr_data.delete();
        ld_idx = 0;
        for (int c = 0; c < 12; c++) begin
            alu_valid = (c < 4);
            alu_rd    = 4'(8 + c);
            alu_data  = 32'(10 + c);
            ld_valid  = (ld_idx < 3);
            ld_rd     = 4'(3 + ld_idx);
            ld_data   = 32'(1 + ld_idx);
            if (c == 2) chk("bp_ld_ready_full", 32'(ld_ready), 32'd0);
            hs = ld_valid && ld_ready;
            tick();
            if (hs) ld_idx++;
            if (WE3) begin
                wr_rd.push_back(A3);
                wr_data.push_back(WD3);
            end
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("bp_write_count", 32'(wr_rd.size()), 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < wr_rd.size()) begin
                chk($sformatf("bp_w%0d_rd", k), 32'(wr_rd[k]), 32'(exp_rd[k]));
                chk($sformatf("bp_w%0d_data", k), wr_data[k], exp_data[k]);
            end
        end

        // same-register ordering: R7=5 then R7=9
        ld_valid = 1'b1; ld_rd = 4'd7; ld_data = 32'd5;
        tick();
        ld_data = 32'd9;
        chk("r7_ready2", 32'(ld_ready), 32'd1);
        for (int e = 1; e <= 2 + LD_LAT; e++) begin
            if (e > 1) tick();
            if (e == 2) ld_valid = 1'b0;
            chk($sformatf("r7_busy_e%0d", e), 32'(busy[7]), (e <= 1 + LD_LAT) ? 32'd1 : 32'd0);
            if (e == LD_LAT) begin
                chk("r7_first_we", 32'(WE3), 32'd1);
                chk("r7_first_a3", 32'(A3), 32'd7);
                chk("r7_first_wd3", WD3, 32'd5);
            end
            if (e == LD_LAT + 1) begin
                chk("r7_second_we", 32'(WE3), 32'd1);
                chk("r7_second_a3", 32'(A3), 32'd7);
                chk("r7_second_wd3", WD3, 32'd9);
            end
        end

        // reset with two loads buffered behind ALU traffic
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 32'd1;
        ld_valid = 1'b1; ld_rd = 4'd9; ld_data = 32'h99;
        tick();
        ld_rd = 4'd10; ld_data = 32'haa;
        tick();
        chk("mid_busy9", 32'(busy[9]), 32'd1);
        chk("mid_busy10", 32'(busy[10]), 32'd1);
        alu_valid = 1'b0; ld_valid = 1'b0; reset = 1'b1;
        #1;
        chk("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("mid_we3_c%0d", c), 32'(WE3), 32'd0);
            chk($sformatf("mid_busy_c%0d", c), 32'(busy), 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
